// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared lock-state enum and select-width helper for mux_arbiter
package mux_arb_pkg;
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: combinational first-valid search starting at ptr and wrapping N-1 -> 0
module rr_pick import mux_arb_pkg::*; #(
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);
  // pick the valid channel with the smallest wrapped distance from ptr
  always_comb begin
    int best;
    best  = N;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = (i - int'(ptr) + N) % N;
      if (valid[i] && d < best) begin
        best  = d;
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: N-way registered mux with explicit-select / round-robin grant; MUX_ARB_LOCK_EN adds packet locking
module mux_arbiter import mux_arb_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_grant
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic [N-1:0]       in_last
`endif
);
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_grant;
  logic [SEL_W-1:0] r_ptr;
  logic             w_accept;
  logic             w_gvalid;
  logic             w_xfer;
  logic             w_locked;
  logic             w_hold;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_lock_ch;
  logic [SEL_W-1:0] w_g;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W-1:0] w_ptr_next;
  logic [WIDTH-1:0] w_data;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_grant = r_out_grant;
  assign w_accept  = !r_out_valid || out_ready;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_rr_pick (
    .valid(in_valid),
    .ptr  (r_ptr),
    .idx  (w_rr_idx),
    .found(w_rr_found)
  );

`ifdef MUX_ARB_LOCK_EN
  lock_state_t      r_state;
  lock_state_t      w_state_next;
  logic [SEL_W-1:0] r_lock_ch;
  logic             w_last;
  assign w_locked  = r_state == LOCKED;
  assign w_lock_ch = r_lock_ch;
  assign w_hold    = w_locked && !w_last;
  // end-of-packet flag of the granted channel
  always_comb begin
    w_last = 1'b0;
    for (int i = 0; i < N; i++)
      if (w_g == SEL_W'(i)) w_last = in_last[i];
  end
  // lock state and the channel a packet is locked to
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lock_ch <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer && !w_locked) r_lock_ch <= w_g;
    end
  end
  // lock on a non-final first beat, release on the final beat
  always_comb begin
    w_state_next = w_locked ? ((w_xfer && w_last) ? IDLE : LOCKED)
                            : ((w_xfer && !w_last) ? LOCKED : IDLE);
  end
`else
  assign w_locked  = 1'b0;
  assign w_lock_ch = '0;
  assign w_hold    = 1'b0;
`endif

  // grant: lock overrides mode; explicit select is void when out of range
  always_comb begin
    w_g        = w_locked ? w_lock_ch : (mode ? w_rr_idx : sel);
    w_gvalid   = w_locked || (mode ? w_rr_found : (32'(sel) < N));
    w_ptr_next = (32'(w_g) == N - 1) ? '0 : w_g + 1'b1;
  end

  // one-hot ready to the granted channel and the matching data mux
  always_comb begin
    in_ready = '0;
    w_data   = '0;
    for (int i = 0; i < N; i++)
      if (w_g == SEL_W'(i)) begin
        in_ready[i] = w_gvalid && w_accept && !reset;
        w_data      = in_data[i*WIDTH +: WIDTH];
      end
  end

  assign w_xfer = |(in_ready & in_valid);

  // output register slice plus round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_grant <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_grant <= w_g;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_xfer && mode && !w_hold) r_ptr <= w_ptr_next;
    end
  end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: scoreboard bench with a reference arbitration model for mux_arbiter
module tb_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic           mode = 1'b0;
  logic [SW-1:0]  sel = '0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [SW-1:0]  out_grant;

  typedef struct {
    logic [W-1:0] d;
    int           g;
  } beat_t;

  beat_t q[$];
  beat_t pbeat;
  bit    pend = 0;
  int    ptr = 0;
  int    checks = 0;
  int    passed = 0;

  mux_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_grant(out_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // one cycle: retire last cycle's predicted beat, drive, then check ready against the model
  task automatic step(input bit rst, input bit m, input int s, input logic [N-1:0] v, input bit r);
    int g;
    bit acc;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    if (pend) q.push_back(pbeat);
    pend = 0;
    if (reset) begin
      q.delete();
      ptr = 0;
    end
    reset     = rst;
    mode      = m;
    sel       = SW'(s);
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    #2;
    acc = (q.size() == 0) || r;
    g   = -1;
    if (!m) g = (s < N) ? s : -1;
    else
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    exp_rdy = '0;
    if (!rst && acc && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", in_ready, exp_rdy);
    if (exp_rdy != 0 && v[g]) begin
      pend    = 1;
      pbeat.d = in_data[g*W +: W];
      pbeat.g = g;
      if (m) ptr = (g + 1) % N;
    end
  endtask

  // monitor: compare the registered beat with the scoreboard head, retire it on handshake
  always @(negedge clk) begin
    check("out_valid", out_valid, q.size() != 0);
    if (out_valid && q.size() != 0) begin
      check("out_data", out_data, q[0].d);
      check("out_grant", out_grant, q[0].g);
      if (out_ready) void'(q.pop_front());
    end
  end

  initial begin
    step(1, 0, 0, '0, 1);
    step(1, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_grant", out_grant, 0);
    step(0, 0, 2, 4'b0100, 1);
    step(0, 0, 0, '0, 1);
    repeat (6) step(0, 1, 0, 4'hf, 1);
    repeat (3) step(0, 1, 0, 4'b1010, 1);
    step(0, 1, 0, 4'hf, 1);
    repeat (3) step(0, 1, 0, 4'hf, 0);
    step(0, 1, 0, 4'hf, 1);
    step(0, 1, 0, 4'b0010, 0);
    step(1, 1, 0, 4'hf, 0);
    step(0, 1, 0, 4'hf, 1);
    step(0, 1, 0, 4'hf, 1);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 50) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, N - 1)), N'($urandom), $urandom_range(0, 3) != 0);
    repeat (3) step(0, 0, 0, '0, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Parametrised N-way, WIDTH-bit multiplexer with a registered valid/ready output and two selection modes: explicit select and round-robin arbitration. It extends our combinational 4:1 bit muxes to the shared-port cases in the datapath, for example fetch and load/store sharing the memory port, or multiple writeback sources. One output register stage gives a fixed one-cycle latency at full throughput.

## Interface
Parameters:
- WIDTH, 32, data bits per channel
- N, 4, number of input channels (N ≥ 1)
- SEL_W, max(1, clog2(N)), select/grant index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready; at most one bit set per cycle
- mode  in  1  0 = explicit select, 1 = round-robin
- sel  in  SEL_W  channel index used when mode = 0
- out_data  out  WIDTH  registered data
- out_valid  out  1  registered valid
- out_ready  in  1  downstream ready
- out_grant  out  SEL_W  registered index of the channel that produced out_data
- in_last  in  N  end-of-packet per channel (only with MUX_ARB_LOCK_EN)

One clock, `clk`. Reset is `reset`, synchronous and active-high.

## Operation
- accept = !out_valid || out_ready.
- Grant g is a combinational function of the current state and inputs:
  - mode 0: g = sel. Grant is void if sel ≥ N.
  - mode 1: g is the first i with in_valid[i] = 1, searching from ptr upward and wrapping N-1 → 0. Grant is void if no valid is set.
- in_ready[g] = accept when the grant is not void. All other in_ready bits are 0.
- Transfer: the granted channel has in_valid[g] && in_ready[g]. On transfer:
  - out_data ← in_data[g], out_grant ← g, out_valid ← 1.
  - In mode 1 only, ptr ← (g+1) mod N.
- If out_ready = 1 and no transfer occurs, out_valid ← 0.
- While out_valid && !out_ready, out_data, out_grant and out_valid hold stable.
- A change to mode or sel takes effect on the next grant evaluation. It never alters a beat already in the register.
- In mode 0, ptr is not modified.
- Reset values: out_valid = 0, out_data = 0, out_grant = 0, ptr = 0, lock state IDLE.

## Timing
- Latency is 1 cycle: a transfer at edge k gives out_valid = 1 after edge k.
- Throughput is 1 beat per cycle when out_ready stays high.
- in_ready depends combinationally on out_ready, in_valid, mode, sel and state. There is no skid buffer.
- Reset asserted mid-stream discards the registered beat. in_ready is all 0 during reset.
- With N = 1, the block degenerates to a single register slice; ptr stays 0.

## Configuration
- MUX_ARB_LOCK_EN defined:
  - Adds the in_last port and a two-state FSM.
  - IDLE → LOCKED on a transfer with in_last[g] = 0. The locked channel index is stored in lock_ch.
  - In LOCKED, g = lock_ch regardless of mode and sel. ptr does not advance.
  - LOCKED → IDLE on a transfer with in_last[lock_ch] = 1. ptr ← lock_ch+1 mod N in mode 1.
  - A single-beat packet (in_last = 1 on the first beat) stays in IDLE.
- MUX_ARB_LOCK_EN undefined:
  - No in_last port and no FSM. Every beat is arbitrated independently.

## Structure
- A shared package, mux_arb_pkg, holds:
  - the lock-state enum (IDLE, LOCKED)
  - the SEL_W computation function
- One sub-module, rr_pick: combinational round-robin first-valid search taking (valid[N], ptr) and returning (idx, found). Used only in mode 1.
- The top level holds the output register, ptr, and the optional lock FSM.

## Test plan
- N=4, WIDTH=32, mode 0, sel=2, in_valid=4'b0100, in_data[2]=0xDEADBEEF, out_ready=1 → in_ready=4'b0100; next cycle out_data=0xDEADBEEF, out_grant=2, out_valid=1.
- Mode 1, all four valid, out_ready=1 for 6 cycles → out_grant sequence 0,1,2,3,0,1.
- Mode 1, only channels 1 and 3 valid, ptr=2 → grant 3, then 1, then 3. Channels 0 and 2 never see ready.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → in_ready=0, out_data stable; out_ready=1 → the next beat transfers in the same cycle.
- Reset asserted while out_valid=1 and ptr=2 → next cycle out_valid=0, and the first mode-1 grant with all channels valid is 0.
- With MUX_ARB_LOCK_EN: channel 1 sends 3 beats with in_last on beat 3 while channel 0 stays valid → grants 1,1,1, then 2 if valid, else 0 (searching from ptr = 2).
